pit_counter_rw: RTL and testbench

//  Per-counter host access stage of the 8254 PIT, directly upstream of the counter ControlLogic.

---
 rtl/pit_pkg.sv | 37 +++
 rtl/pit_rd_byte_sel.sv | 25 ++
 rtl/pit_counter_rw.sv | 178 +++++++++++++++++
 tb/tb_pit_counter_rw.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pit_pkg.sv
// rtl/pit_pkg.sv - shared encodings and field positions for the 8254 counter host-access stage
package pit_pkg;

    typedef enum logic [1:0] {
        RW_LATCH   = 2'b00,
        RW_LSB     = 2'b01,
        RW_MSB     = 2'b10,
        RW_LSB_MSB = 2'b11
    } rw_e;

    localparam logic [1:0] ADDR_CW = 2'b11;

    // Control word fields
    localparam int CW_SC_HI  = 7;
    localparam int CW_SC_LO  = 6;
    localparam int CW_RW_HI  = 5;
    localparam int CW_RW_LO  = 4;
    localparam int CW_M_HI   = 3;
    localparam int CW_M_LO   = 1;
    localparam int CW_BCD    = 0;

    // Status byte fields; the low six bits mirror the control word
    localparam int STATUS_OUT  = 7;
    localparam int STATUS_NULL = 6;

    // Read-back command fields
    localparam logic [1:0] RB_CMD       = 2'b11;
    localparam int         RB_NO_COUNT  = 5;
    localparam int         RB_NO_STATUS = 4;
    localparam int         RB_SEL_BASE  = 1;
    localparam int         RB_RSVD      = 0;

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic msb);
        return msb ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/pit_rd_byte_sel.sv
// rtl/pit_rd_byte_sel.sv - read source priority (status > output latch > live) and LSB/MSB select
module pit_rd_byte_sel
    import pit_pkg::*;
(
    input  rw_e         rw,
    input  logic        rptr,
    input  logic        st_valid,
    input  logic [7:0]  st,
    input  logic        ol_valid,
    input  logic [15:0] ol,
    input  logic [15:0] live,
    output logic [7:0]  rd_byte
);

    logic [15:0] src;
    logic        msb;

    always_comb begin
        src = ol_valid ? ol : live;
        // Unprogrammed (RW=00) counters fall back to showing the LSB
        msb = (rw == RW_MSB) || ((rw == RW_LSB_MSB) && rptr);
        rd_byte = st_valid ? st : pick_byte(src, msb);
    end

endmodule

// File: rtl/pit_counter_rw.sv
// rtl/pit_counter_rw.sv - 8254 per-counter host access: CW/CR writes, latches, byte-sequenced reads; PIT_READBACK_EN adds read-back
module pit_counter_rw
    import pit_pkg::*;
#(
    parameter logic [1:0] COUNTER_ID = 2'b00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CS,
    input  logic        RD,
    input  logic        WR,
    input  logic [1:0]  A,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [15:0] current_count,
    input  logic        OUT,
    input  logic        load_new_count,
    output logic [7:0]  control_word,
    output logic [15:0] initial_count,
    output logic        cr_written,
    output logic        null_count,
    output logic [7:0]  statusByte
);

    logic        wr_q, w_cs_q;
    logic [1:0]  w_a_q;
    logic [7:0]  w_d_q;
    logic        rd_q, r_cs_q;
    logic [1:0]  r_a_q;

    logic        wptr, rptr;
    logic        ol_valid;
    logic [15:0] ol;
    logic        st_valid;
    logic [7:0]  st;

    rw_e         rw;
    logic        write_commit, read_commit;
    logic        cw_hit, cw_load, cnt_latch_cmd, data_wr, data_complete;
    logic        rb_cnt;
    logic [7:0]  rd_byte;

    assign rw = rw_e'(control_word[CW_RW_HI:CW_RW_LO]);

    // Bus cycles commit on the rising edge of the strobe, using what was captured while it was low
    assign write_commit = !wr_q && WR && !w_cs_q;
    assign read_commit  = !rd_q && RD && !r_cs_q && (r_a_q == COUNTER_ID);

    assign cw_hit        = write_commit && (w_a_q == ADDR_CW) && (w_d_q[CW_SC_HI:CW_SC_LO] == COUNTER_ID);
    assign cw_load       = cw_hit && (w_d_q[CW_RW_HI:CW_RW_LO] != RW_LATCH);
    assign cnt_latch_cmd = cw_hit && (w_d_q[CW_RW_HI:CW_RW_LO] == RW_LATCH);
    assign data_wr       = write_commit && (w_a_q == COUNTER_ID);
    assign data_complete = data_wr && ((rw == RW_LSB) || (rw == RW_MSB) || ((rw == RW_LSB_MSB) && wptr));

    assign statusByte = {OUT, null_count, control_word[CW_RW_HI:CW_RW_LO],
                         control_word[CW_M_HI:CW_M_LO], control_word[CW_BCD]};

`ifdef PIT_READBACK_EN
    localparam int RB_SEL_BIT = RB_SEL_BASE + int'(COUNTER_ID);

    logic rb_hit;

    assign rb_hit = write_commit && (w_a_q == ADDR_CW) && (w_d_q[CW_SC_HI:CW_SC_LO] == RB_CMD)
                    && w_d_q[RB_SEL_BIT] && !w_d_q[RB_RSVD];
    assign rb_cnt = rb_hit && !w_d_q[RB_NO_COUNT];

    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid <= 1'b0;
            st       <= 8'h00;
        end else if (cw_load) begin
            st_valid <= 1'b0;
        end else if (read_commit && st_valid) begin
            st_valid <= 1'b0;
        end else if (rb_hit && !w_d_q[RB_NO_STATUS] && !st_valid) begin
            st_valid <= 1'b1;
            st       <= statusByte;
        end
    end
`else
    assign rb_cnt   = 1'b0;
    assign st_valid = 1'b0;
    assign st       = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q          <= 1'b1;
            w_cs_q        <= 1'b1;
            w_a_q         <= 2'b00;
            w_d_q         <= 8'h00;
            rd_q          <= 1'b1;
            r_cs_q        <= 1'b1;
            r_a_q         <= 2'b00;
            control_word  <= 8'h00;
            initial_count <= 16'h0000;
            cr_written    <= 1'b0;
            null_count    <= 1'b1;
            wptr          <= 1'b0;
            rptr          <= 1'b0;
            ol_valid      <= 1'b0;
            ol            <= 16'h0000;
        end else begin
            wr_q <= WR;
            if (!WR) begin
                w_cs_q <= CS;
                w_a_q  <= A;
                w_d_q  <= d_in;
            end
            rd_q <= RD;
            if (!RD) begin
                r_cs_q <= CS;
                r_a_q  <= A;
            end

            cr_written <= data_complete;

            // A completed write wins over a simultaneous CR->CE transfer
            if (cw_load || data_complete)
                null_count <= 1'b1;
            else if (load_new_count)
                null_count <= 1'b0;

            if (cw_load) begin
                control_word <= w_d_q;
                wptr         <= 1'b0;
                rptr         <= 1'b0;
                ol_valid     <= 1'b0;
            end else begin
                if (data_wr) begin
                    case (rw)
                        RW_LSB: initial_count <= {8'h00, w_d_q};
                        RW_MSB: initial_count <= {w_d_q, 8'h00};
                        RW_LSB_MSB: begin
                            if (wptr)
                                initial_count[15:8] <= w_d_q;
                            else
                                initial_count[7:0] <= w_d_q;
                            wptr <= !wptr;
                        end
                        default: ;
                    endcase
                end

                if (read_commit && !st_valid) begin
                    if (rw == RW_LSB_MSB) begin
                        rptr <= !rptr;
                        if (rptr)
                            ol_valid <= 1'b0;
                    end else if (rw != RW_LATCH) begin
                        ol_valid <= 1'b0;
                    end
                end

                if ((cnt_latch_cmd || rb_cnt) && !ol_valid) begin
                    ol       <= current_count;
                    ol_valid <= 1'b1;
                end
            end
        end
    end

    pit_rd_byte_sel u_rd_byte_sel (
        .rw       (rw),
        .rptr     (rptr),
        .st_valid (st_valid),
        .st       (st),
        .ol_valid (ol_valid),
        .ol       (ol),
        .live     (current_count),
        .rd_byte  (rd_byte)
    );

    assign d_oe  = !reset && !CS && !RD && WR && (A == COUNTER_ID);
    assign d_out = d_oe ? rd_byte : 8'h00;

endmodule

// File: tb/tb_pit_counter_rw.sv
// tb/tb_pit_counter_rw.sv - scoreboard bench for pit_counter_rw (both PIT_READBACK_EN builds)
module tb_pit_counter_rw;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        CS = 1'b1, RD = 1'b1, WR = 1'b1;
    logic [1:0]  A = 2'b00;
    logic [7:0]  d_in = 8'h00;
    logic [15:0] current_count = 16'h0000;
    logic        OUT = 1'b0;
    logic        load_new_count = 1'b0;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  control_word;
    logic [15:0] initial_count;
    logic        cr_written;
    logic        null_count;
    logic [7:0]  statusByte;

    pit_counter_rw #(.COUNTER_ID(2'b00)) dut (
        .clk            (clk),
        .reset          (reset),
        .CS             (CS),
        .RD             (RD),
        .WR             (WR),
        .A              (A),
        .d_in           (d_in),
        .d_out          (d_out),
        .d_oe           (d_oe),
        .current_count  (current_count),
        .OUT            (OUT),
        .load_new_count (load_new_count),
        .control_word   (control_word),
        .initial_count  (initial_count),
        .cr_written     (cr_written),
        .null_count     (null_count),
        .statusByte     (statusByte)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [15:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 16'd1, 16'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input bit lnc,
                             input bit exp_cr, input string tag);
        sb_push({tag, "_crw"}, {15'd0, exp_cr});
        @(posedge clk); #1;
        CS = 1'b0; A = a; d_in = d; WR = 1'b0;
        @(posedge clk); #1;
        WR = 1'b1; CS = 1'b1; load_new_count = lnc;
        @(posedge clk); #1;
        load_new_count = 1'b0;
        sb_pop_check({15'd0, cr_written});
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string tag);
        sb_push(tag, {8'h00, exp});
        @(posedge clk); #1;
        CS = 1'b0; A = a; RD = 1'b0;
        #2;
        check_eq({tag, "_oe"}, {15'd0, d_oe}, 16'd1);
        sb_pop_check({8'h00, d_out});
        @(posedge clk); #1;
        RD = 1'b1; CS = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_lnc();
        @(posedge clk); #1;
        load_new_count = 1'b1;
        @(posedge clk); #1;
        load_new_count = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; CS = 1'b1; RD = 1'b1; WR = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_status;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cw", {8'h00, control_word}, 16'h0000);
        check_eq("rst_cr", initial_count, 16'h0000);
        check_eq("rst_crw", {15'd0, cr_written}, 16'd0);
        check_eq("rst_null", {15'd0, null_count}, 16'd1);
        check_eq("rst_doe", {15'd0, d_oe}, 16'd0);
        check_eq("rst_dout", {8'h00, d_out}, 16'h0000);
        reset = 1'b0;

        // LSB then MSB in RW=11 mode
        bus_write(2'b11, 8'h34, 0, 0, "t1_cw");
        check_eq("t1_cwreg", {8'h00, control_word}, 16'h0034);
        bus_write(2'b00, 8'hCD, 0, 0, "t1_lsb");
        bus_write(2'b00, 8'hAB, 0, 1, "t1_msb");
        check_eq("t1_cr", initial_count, 16'hABCD);
        check_eq("t1_null", {15'd0, null_count}, 16'd1);
        @(posedge clk); #1;
        check_eq("t1_crw_single", {15'd0, cr_written}, 16'd0);

        // null_count clear, and write-wins collision
        pulse_lnc();
        check_eq("t2_null_clr", {15'd0, null_count}, 16'd0);
        bus_write(2'b00, 8'h11, 0, 0, "t2_lsb");
        check_eq("t2_null_partial", {15'd0, null_count}, 16'd0);
        bus_write(2'b00, 8'h22, 1, 1, "t2_msb_lnc");
        check_eq("t2_null_win", {15'd0, null_count}, 16'd1);
        check_eq("t2_cr", initial_count, 16'h2211);

        // Single-byte modes
        bus_write(2'b11, 8'h14, 0, 0, "t3_cw01");
        bus_write(2'b00, 8'h7F, 0, 1, "t3_lsb");
        check_eq("t3_cr01", initial_count, 16'h007F);
        bus_write(2'b11, 8'h24, 0, 0, "t3_cw10");
        bus_write(2'b00, 8'h12, 0, 1, "t3_msb");
        check_eq("t3_cr10", initial_count, 16'h1200);
        current_count = 16'hABCD;
        bus_read(2'b00, 8'hAB, "t3_rd_msb_live");

        // Counter latch: first latch wins
        bus_write(2'b11, 8'h34, 0, 0, "t4_cw");
        current_count = 16'h1234;
        bus_write(2'b11, 8'h00, 0, 0, "t4_latch1");
        current_count = 16'h0FFF;
        bus_write(2'b11, 8'h00, 0, 0, "t4_latch2");
        bus_read(2'b00, 8'h34, "t4_rd_lsb");
        bus_read(2'b00, 8'h12, "t4_rd_msb");
        bus_read(2'b00, 8'hFF, "t4_rd_live_lsb");
        bus_read(2'b00, 8'h0F, "t4_rd_live_msb");

        // Control word register is write-only
        @(posedge clk); #1;
        CS = 1'b0; A = 2'b11; RD = 1'b0;
        #2;
        check_eq("t4_cwreg_noe", {15'd0, d_oe}, 16'd0);
        @(posedge clk); #1;
        RD = 1'b1; CS = 1'b1;
        @(posedge clk); #1;

        // Read-back command
        bus_write(2'b11, 8'h36, 0, 0, "t5_cw");
        bus_write(2'b00, 8'h00, 0, 0, "t5_lsb");
        bus_write(2'b00, 8'h10, 0, 1, "t5_msb");
        pulse_lnc();
        check_eq("t5_null", {15'd0, null_count}, 16'd0);
        OUT = 1'b1;
        current_count = 16'h5678;
        exp_status = {1'b1, 1'b0, 2'b11, 3'b011, 1'b0};
        @(posedge clk); #1;
        check_eq("t5_status", {8'h00, statusByte}, {8'h00, exp_status});
        bus_write(2'b11, 8'hC2, 0, 0, "t5_rb");
        current_count = 16'h9A11;
`ifdef PIT_READBACK_EN
        bus_read(2'b00, exp_status, "t5_rd_status");
        bus_read(2'b00, 8'h78, "t5_rd_ol_lsb");
        bus_read(2'b00, 8'h56, "t5_rd_ol_msb");
        bus_read(2'b00, 8'h11, "t5_rd_live_lsb");
        bus_read(2'b00, 8'h9A, "t5_rd_live_msb");
`else
        check_eq("t5_cw_kept", {8'h00, control_word}, 16'h0036);
        check_eq("t5_null_kept", {15'd0, null_count}, 16'd0);
        bus_read(2'b00, 8'h11, "t5_rd_live_lsb");
        bus_read(2'b00, 8'h9A, "t5_rd_live_msb");
`endif

        // Reset between LSB and MSB
        bus_write(2'b11, 8'h34, 0, 0, "t6_cw");
        bus_write(2'b00, 8'hEF, 0, 0, "t6_lsb");
        do_reset();
        check_eq("t6_cw", {8'h00, control_word}, 16'h0000);
        check_eq("t6_cr", initial_count, 16'h0000);
        check_eq("t6_null", {15'd0, null_count}, 16'd1);
        bus_write(2'b00, 8'h55, 0, 0, "t6_ign");
        check_eq("t6_cr_ign", initial_count, 16'h0000);
        bus_write(2'b11, 8'h34, 0, 0, "t6_cw2");
        bus_write(2'b00, 8'hAA, 0, 0, "t6_lsb2");
        bus_write(2'b00, 8'hBB, 0, 1, "t6_msb2");
        check_eq("t6_cr2", initial_count, 16'hBBAA);

        check_eq("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
